imem_dmem_arbiter: RTL
======================

# imem_dmem_arbiter

Arbiter that shares one single-port unified memory between the instruction-fetch stage and the MEM-stage load/store port of the 5-stage pipeline. It serialises requests, drives the memory handshake, and routes read data back to the winning requester. It also generates the pipeline write-enable/hold signals, alongside the load-use hazard logic, so that the PC, IF/ID and later pipeline registers freeze while an access is pending. A watchdog aborts accesses the memory never acknowledges.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum cycles a granted access waits for mem_ready (≥2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_done  out  1  fetch complete this cycle
- if_rdata  out  DATA_W  fetch data, valid with if_done
- d_req  in  1  data request, held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  data access complete this cycle
- d_rdata  out  DATA_W  load data, valid with d_done
- mem_req  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes current access this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register write enable
- pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB
- bus_err  out  1  sticky: a watchdog abort occurred

## Operation
- States: IDLE, FETCH, DATA.
- IDLE:
  - If d_req and (!if_req or last_grant == FETCH), go to DATA.
  - Else if if_req, go to FETCH.
  - On a grant, latch address (and we/wdata for DATA) into request registers, set last_grant and clear wait_cnt.
- FETCH/DATA:
  - mem_req = 1; mem_addr/mem_we/mem_wdata come from the latched registers and stay stable until completion.
  - mem_we = 0 in FETCH.
- Completion occurs when mem_ready = 1 in FETCH/DATA:
  - if_done (FETCH) or d_done (DATA) = 1 combinationally that cycle.
  - The matching rdata = mem_rdata (0 for stores). Next state is IDLE.
- Watchdog:
  - wait_cnt increments each FETCH/DATA cycle with mem_ready = 0.
  - If mem_ready = 0 and wait_cnt == TIMEOUT-1, abort: done pulses, rdata = 0, bus_err set, next state IDLE.
  - mem_ready takes precedence over abort in the same cycle.
- Fairness: strict alternation when both requesters are pending; data wins ties after reset and after a fetch grant.
- Stall outputs (combinational):
  - pipe_hold = d_req & !d_done.
  - pc_write = if_id_write = !((if_req & !if_done) | pipe_hold).
- Done outputs are 0 outside FETCH/DATA; rdata outputs are 0 when their done is 0.
- A requester change of address/data after grant has no effect on the latched access.

## Timing
- Reset (cycle after rst sampled high):
  - State IDLE, last_grant = FETCH, wait_cnt = 0, bus_err = 0.
  - Request registers cleared; mem_req = mem_we = 0; mem_addr = mem_wdata = 0.
  - if_done = d_done = 0; if_rdata = d_rdata = 0.
- Mid-transaction reset: the access is dropped with no done pulse; mem_req is low in the cycle after the rst edge. Outputs driven by request inputs still follow the combinational equations.
- Latency: request seen in IDLE at cycle N, mem_req high from N+1, done earliest at N+1, IDLE at N+2.
- Minimum spacing between grants is 2 cycles; maximum throughput is 1 access per 2 cycles.
- A requester deasserts or changes its req in the cycle after its done. A req still high in the IDLE cycle after done is treated as a new request.

## Test plan
- Fetch only, mem_ready tied 1:
  - if_req = 1, if_addr = 0x100 at cycle 0 (state IDLE).
  - Required: mem_req = 1 with mem_addr = 0x100 and mem_we = 0 at cycle 1; if_done = 1 with if_rdata = mem_rdata at cycle 1.
  - pc_write = 0 at cycle 0, 1 at cycle 1.
- Simultaneous first requests after reset:
  - if_req = d_req = 1, d_addr = 0x40, d_we = 1, d_wdata = 0xDEADBEEF.
  - Required: DATA first with mem_we = 1, mem_wdata = 0xDEADBEEF and pipe_hold = 1 until d_done; then FETCH.
- Both reqs held high for 8 grants: grant order D, F, D, F, …; every transaction separated by exactly one IDLE cycle.
- Slow memory, mem_ready after 3 low cycles on a load:
  - mem_addr stable for all 4 cycles; d_done only in cycle 4.
  - pipe_hold = 1 and pc_write = 0 throughout the wait; bus_err stays 0.
- Watchdog with TIMEOUT = 4, mem_ready held 0 on a fetch:
  - mem_req high for exactly 4 cycles; if_done = 1 with if_rdata = 0 in the 4th.
  - bus_err = 1 and remains 1 until rst.
- rst asserted during cycle 2 of a pending DATA access: mem_req = 0 the following cycle, no d_done pulse, bus_err = 0; the next simultaneous request grants DATA first.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM-stage load/store port.
// Latency: grant one cycle after a request is seen in IDLE, done combinationally on mem_ready (earliest same cycle as grant+1).
// Backpressure: requesters hold req until done; pipeline stalls via pc_write/if_id_write/pipe_hold; watchdog aborts hung accesses.
module imem_dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  // data (load/store) port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  // unified memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // pipeline stall controls
  output logic              pc_write,
  output logic              if_id_write,
  output logic              pipe_hold,
  output logic              bus_err
);

  // wait_cnt never exceeds TIMEOUT-1, so clog2(TIMEOUT) bits are enough.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  typedef enum logic {
    GR_FETCH = 1'b0,
    GR_DATA  = 1'b1
  } grant_t;

  state_t            state;
  state_t            state_nxt;
  grant_t            last_grant;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;

  logic              active;
  logic              hit;
  logic              abort;
  logic              complete;
  logic              grant_f;
  logic              grant_d;

  // Next-state, grant decisions and completion/abort detection.
  always_comb begin
    state_nxt = state;
    grant_f   = 1'b0;
    grant_d   = 1'b0;
    active    = (state != IDLE);
    // mem_ready wins over the watchdog when both land in the same cycle
    hit       = active & mem_ready;
    abort     = active & ~mem_ready & (wait_cnt == CNT_LAST);
    complete  = hit | abort;
    case (state)
      IDLE: begin
        // Data wins a tie unless it had the previous grant: strict alternation.
        if (d_req && (!if_req || last_grant == GR_FETCH)) begin
          state_nxt = DATA;
          grant_d   = 1'b1;
        end else if (if_req) begin
          state_nxt = FETCH;
          grant_f   = 1'b1;
        end
      end
      FETCH, DATA: begin
        if (complete) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request latches, fairness memory, watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GR_FETCH;
      wait_cnt   <= '0;
      bus_err    <= 1'b0;
      req_addr   <= '0;
      req_we     <= 1'b0;
      req_wdata  <= '0;
    end else begin
      if (grant_d) begin
        req_addr   <= d_addr;
        req_we     <= d_we;
        req_wdata  <= d_wdata;
        last_grant <= GR_DATA;
        wait_cnt   <= '0;
      end else if (grant_f) begin
        req_addr   <= if_addr;
        req_we     <= 1'b0;
        req_wdata  <= '0;
        last_grant <= GR_FETCH;
        wait_cnt   <= '0;
      end else if (active && !mem_ready && !abort) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (abort) begin
        bus_err <= 1'b1;
      end
    end
  end

  // Memory handshake driven from the latched request so it is stable for the whole access.
  always_comb begin
    mem_req   = active;
    mem_we    = (state == DATA) & req_we;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
  end

  // Done pulses and read-data routing; a reset cycle drops the access without a done.
  always_comb begin
    if_done  = (state == FETCH) & complete & ~rst;
    d_done   = (state == DATA)  & complete & ~rst;
    if_rdata = (if_done && hit) ? mem_rdata : '0;
    d_rdata  = (d_done && hit && !req_we) ? mem_rdata : '0;
  end

  // Pipeline freeze: anything still waiting on memory holds the front end.
  always_comb begin
    pipe_hold   = d_req & ~d_done;
    pc_write    = ~((if_req & ~if_done) | pipe_hold);
    if_id_write = pc_write;
  end

endmodule
